frequency_gate_controller: RTL and testbench
============================================

FREQUENCY_GATE_CONTROLLER -- requirements
Module: frequency_gate_controller

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 25_000_000: Clock frequency in Hz; SHALL be a multiple of 100 and >= 100.
REQ-002 SHALL have parameter COUNT_BITS, default 24: width of the external edge counter value.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 3: idle cycles after the gate closes, covering the signal synchronizer depth.
REQ-004 SHALL have parameter LOW_COUNT, default 1000: count below which the next measurement uses a longer gate.
REQ-005 SHALL have port Clock, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port Reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port Enable_i, input, 1: continuous-measurement request.
REQ-008 SHALL have port CounterClear_o, output, 1: clears the external edge counter.
REQ-009 SHALL have port CounterEnable_o, output, 1: gate; the external counter counts input edges while high.
REQ-010 SHALL have port CounterValue_i, input, COUNT_BITS: external counter value.
REQ-011 SHALL have port CounterOverflow_i, input, 1: external counter saturated (sticky until clear).
REQ-012 SHALL have port Result_o, output, 32: measured frequency in Hz.
REQ-013 SHALL have port Range_o, output, 2: gate used for Result_o (0 = 1 s, 1 = 100 ms, 2 = 10 ms).
REQ-014 SHALL have port Overrange_o, output, 1: input frequency exceeds the measurable range.
REQ-015 SHALL have port Valid_o, output, 1: Result_o, Range_o and Overrange_o are valid.
REQ-016 SHALL have port Ready_i, input, 1: downstream (BCD/display) accepts the result.
REQ-017 SHALL have port Busy_o, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, GATE, SETTLE, LATCH, PUBLISH.
REQ-019 IDLE SHALL go to CLEAR on the edge where Enable_i=1; otherwise stay in IDLE.
REQ-020 CLEAR SHALL last exactly 1 cycle with CounterClear_o=1, then go to GATE.
REQ-021 GATE SHALL hold CounterEnable_o=1 for exactly G cycles, then go to SETTLE.
REQ-022 G SHALL be CLOCK_HZ for range 0, CLOCK_HZ/10 for range 1 and CLOCK_HZ/100 for range 2.
REQ-023 SETTLE SHALL last SETTLE_CYCLES cycles with CounterEnable_o=0, then go to LATCH.
REQ-024 LATCH SHALL last 1 cycle and sample CounterValue_i and CounterOverflow_i.
REQ-025 In LATCH, if CounterOverflow_i=1 and range < 2: range SHALL increment, nothing SHALL be published, and the next state SHALL be CLEAR.
REQ-026 In LATCH, if CounterOverflow_i=1 and range = 2: the block SHALL load Result_o=32'hFFFFFFFF and Overrange_o=1, then go to PUBLISH.
REQ-027 In LATCH, otherwise: Result_o SHALL be CounterValue_i x {1, 10, 100} by range, zero-extended to 32 bits; Overrange_o=0; next state PUBLISH.
REQ-028 PUBLISH SHALL hold Valid_o=1 with Result_o, Range_o and Overrange_o stable until the cycle where Ready_i=1; that cycle is the handshake.
REQ-029 Valid_o SHALL be low in the cycle after the handshake.
REQ-030 On the handshake, if the published count < LOW_COUNT and range > 0, range SHALL decrement for the next measurement.
REQ-031 On the handshake, the FSM SHALL go to CLEAR if Enable_i=1, else to IDLE.
REQ-032 Enable_i deasserted mid-measurement SHALL NOT abort it; the result SHALL still be published, then the FSM returns to IDLE.
REQ-033 Latency SHALL be fixed: with Enable_i sampled high in IDLE at edge k, CLEAR occupies cycle k+1, GATE k+2..k+1+G, and Valid_o rises at k+3+G+SETTLE_CYCLES.
REQ-034 The gate timer SHALL be wide enough for CLOCK_HZ-1 and SHALL NOT wrap.
REQ-035 CounterClear_o and CounterEnable_o SHALL never be high in the same cycle.

Reset
REQ-036 While Reset=1 the block SHALL go to IDLE with range=0, timers=0, and all outputs 0 (Result_o=0, Valid_o=0, Busy_o=0, CounterClear_o=0, CounterEnable_o=0, Overrange_o=0).
REQ-037 Reset asserted in any state, including mid-GATE or mid-PUBLISH, SHALL take effect at the next rising edge; a pending result SHALL be discarded.

Verification
Bench parameters for all scenarios: CLOCK_HZ=1000, COUNT_BITS=8, SETTLE_CYCLES=3, LOW_COUNT=50.
REQ-038 Basic: Enable_i=1, Ready_i=1, model returns count 120 -> one-cycle clear; gate high exactly 1000 cycles; Valid_o at k+1006; Result_o=120, Range_o=0.
REQ-039 Autorange: overflow at range 0 -> no Valid_o, immediate CLEAR, 100-cycle gate; count 40 -> Result_o=400, Range_o=1; next gate is 1000 cycles (range 0).
REQ-040 Overrange: overflow at ranges 0, 1 and 2 -> single Valid_o with Overrange_o=1, Result_o=32'hFFFFFFFF, Range_o=2.
REQ-041 Backpressure: Ready_i=0 for 20 cycles in PUBLISH -> Valid_o and outputs stable, no CounterClear_o; Ready_i=1 -> Valid_o low next cycle, CLEAR follows.
REQ-042 Reset mid-GATE -> next cycle CounterEnable_o=0, Busy_o=0, Valid_o=0, range 0; with Enable_i=1 a new measurement starts from CLEAR.
REQ-043 Enable_i dropped mid-GATE -> gate completes its full length, result published, then IDLE with no further CounterClear_o.

Source files
------------

// File: rtl/frequency_gate_controller.sv
// -----------------------------------------------------------------------------
// frequency_gate_controller
//
// Sequences an external edge counter to measure a signal frequency. The
// counter is cleared and then gated for 1 s, 100 ms or 10 ms. The count is
// scaled to Hz and handed downstream with a valid/ready handshake.
// Autoranging works in both directions:
//   - A counter overflow moves to a shorter gate and re-measures without
//     publishing.
//   - A small count moves the next measurement to a longer gate.
//
// Parameters
//   CLOCK_HZ      : clock frequency in Hz (multiple of 100, >= 100)
//   COUNT_BITS    : width of the external counter value (<= 32)
//   SETTLE_CYCLES : idle cycles after the gate closes (>= 1), covering the
//                   input synchronizer depth of the external counter
//   LOW_COUNT     : a published count below this selects a longer next gate
//
// Ports
//   Clock             : clock, rising edge
//   Reset             : synchronous active-high reset
//   Enable_i          : continuous-measurement request
//   CounterClear_o    : clears the external counter (one cycle)
//   CounterEnable_o   : gate, the external counter counts while high
//   CounterValue_i    : external counter value
//   CounterOverflow_i : external counter saturated (sticky until clear)
//   Result_o          : measured frequency in Hz
//   Range_o           : gate used for Result_o (0 = 1 s, 1 = 100 ms, 2 = 10 ms)
//   Overrange_o       : input frequency beyond the measurable range
//   Valid_o           : Result_o / Range_o / Overrange_o valid
//   Ready_i           : downstream accepts the result
//   Busy_o            : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module frequency_gate_controller #(
  parameter int CLOCK_HZ      = 25_000_000,
  parameter int COUNT_BITS    = 24,
  parameter int SETTLE_CYCLES = 3,
  parameter int LOW_COUNT     = 1000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable_i,
  output logic                  CounterClear_o,
  output logic                  CounterEnable_o,
  input  logic [COUNT_BITS-1:0] CounterValue_i,
  input  logic                  CounterOverflow_i,
  output logic [31:0]           Result_o,
  output logic [1:0]            Range_o,
  output logic                  Overrange_o,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic                  Busy_o
);

  // The gate timer counts down from G-1 to 0, so CLOCK_HZ-1 must fit.
  localparam int GATE_W   = $clog2(CLOCK_HZ);
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [GATE_W-1:0]   GATE_LAST_1S    = GATE_W'(CLOCK_HZ - 1);
  localparam logic [GATE_W-1:0]   GATE_LAST_100MS = GATE_W'(CLOCK_HZ / 10 - 1);
  localparam logic [GATE_W-1:0]   GATE_LAST_10MS  = GATE_W'(CLOCK_HZ / 100 - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST     =
    SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [31:0]         LOW_COUNT_32    = 32'(LOW_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH,
    PUBLISH
  } state_t;

  state_t                state_q, state_d;
  logic [GATE_W-1:0]     gate_timer_q;
  logic [SETTLE_W-1:0]   settle_timer_q;
  logic [1:0]            range_q;
  logic [COUNT_BITS-1:0] count_q;
  logic [31:0]           result_q;
  logic                  overrange_q;
  logic [31:0]           scaled_value;
  logic                  overflow_retry;

  function automatic logic [GATE_W-1:0] gate_last(input logic [1:0] range);
    case (range)
      2'd0:    gate_last = GATE_LAST_1S;
      2'd1:    gate_last = GATE_LAST_100MS;
      default: gate_last = GATE_LAST_10MS;
    endcase
  endfunction

  // Next state, outputs and datapath helpers.
  // NOTE: every signal gets a default before the case so that no path leaves
  // it unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d         = state_q;
    CounterClear_o  = 1'b0;
    CounterEnable_o = 1'b0;
    Valid_o         = 1'b0;
    Busy_o          = (state_q != IDLE);
    overflow_retry  = CounterOverflow_i && (range_q < 2'd2);

    case (range_q)
      2'd0:    scaled_value = 32'(CounterValue_i);
      2'd1:    scaled_value = 32'(CounterValue_i) * 32'd10;
      default: scaled_value = 32'(CounterValue_i) * 32'd100;
    endcase

    case (state_q)
      IDLE: begin
        if (Enable_i) state_d = CLEAR;
      end
      CLEAR: begin
        CounterClear_o = 1'b1;
        state_d        = GATE;
      end
      GATE: begin
        CounterEnable_o = 1'b1;
        if (gate_timer_q == '0) state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_timer_q == '0) state_d = LATCH;
      end
      LATCH: begin
        // An overflow at a longer gate retries at the next shorter gate.
        state_d = overflow_retry ? CLEAR : PUBLISH;
      end
      PUBLISH: begin
        Valid_o = 1'b1;
        if (Ready_i) state_d = Enable_i ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Result_o    = result_q;
  assign Range_o     = range_q;
  assign Overrange_o = overrange_q;

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: every register, including the published result, is reset, so a
      // pending result is discarded and all outputs read 0 after reset.
      state_q        <= IDLE;
      gate_timer_q   <= '0;
      settle_timer_q <= '0;
      range_q        <= 2'd0;
      count_q        <= '0;
      result_q       <= '0;
      overrange_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        CLEAR: gate_timer_q <= gate_last(range_q);
        GATE: begin
          // The timer holds at zero instead of wrapping.
          if (gate_timer_q != '0) gate_timer_q <= gate_timer_q - GATE_W'(1);
          else                    settle_timer_q <= SETTLE_LAST;
        end
        SETTLE: begin
          if (settle_timer_q != '0) settle_timer_q <= settle_timer_q - SETTLE_W'(1);
        end
        LATCH: begin
          if (overflow_retry) begin
            range_q <= range_q + 2'd1;
          end else if (CounterOverflow_i) begin
            // A saturated count never asks for a longer gate.
            count_q     <= '1;
            result_q    <= 32'hFFFF_FFFF;
            overrange_q <= 1'b1;
          end else begin
            count_q     <= CounterValue_i;
            result_q    <= scaled_value;
            overrange_q <= 1'b0;
          end
        end
        PUBLISH: begin
          if (Ready_i && (32'(count_q) < LOW_COUNT_32) && (range_q != 2'd0))
            range_q <= range_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_gate_controller.sv
// -----------------------------------------------------------------------------
// tb_frequency_gate_controller
//
// Directed test of frequency_gate_controller with CLOCK_HZ=1000, COUNT_BITS=8,
// SETTLE_CYCLES=3 and LOW_COUNT=50. This gives gates of 1000/100/10 cycles.
//
// A small counter model answers each gate with the next entry from a response
// queue. The entry is driven when the gate closes, and a clear zeroes it.
// The model also records gate lengths, clear pulses, Valid_o pulses and any
// overlap of clear and gate.
// -----------------------------------------------------------------------------
module tb_frequency_gate_controller;

  localparam int CLOCK_HZ      = 1000;
  localparam int COUNT_BITS    = 8;
  localparam int SETTLE_CYCLES = 3;
  localparam int LOW_COUNT     = 50;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic                  Enable_i;
  logic                  CounterClear_o;
  logic                  CounterEnable_o;
  logic [COUNT_BITS-1:0] CounterValue_i;
  logic                  CounterOverflow_i;
  logic [31:0]           Result_o;
  logic [1:0]            Range_o;
  logic                  Overrange_o;
  logic                  Valid_o;
  logic                  Ready_i;
  logic                  Busy_o;

  frequency_gate_controller #(
    .CLOCK_HZ     (CLOCK_HZ),
    .COUNT_BITS   (COUNT_BITS),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOW_COUNT    (LOW_COUNT)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Enable_i         (Enable_i),
    .CounterClear_o   (CounterClear_o),
    .CounterEnable_o  (CounterEnable_o),
    .CounterValue_i   (CounterValue_i),
    .CounterOverflow_i(CounterOverflow_i),
    .Result_o         (Result_o),
    .Range_o          (Range_o),
    .Overrange_o      (Overrange_o),
    .Valid_o          (Valid_o),
    .Ready_i          (Ready_i),
    .Busy_o           (Busy_o)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // External counter model and monitors
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [COUNT_BITS-1:0] value;
    logic                  ovf;
  } resp_t;

  resp_t resp_q[$];
  int    clear_cnt   = 0;
  int    valid_cnt   = 0;
  int    overlap_cnt = 0;
  int    gate_run    = 0;
  int    last_gate   = 0;
  logic  prev_en     = 1'b0;
  logic  prev_valid  = 1'b0;

  always @(negedge Clock) begin
    resp_t r;
    if (Reset) begin
      CounterValue_i    = '0;
      CounterOverflow_i = 1'b0;
    end
    if (CounterClear_o) begin
      clear_cnt++;
      CounterValue_i    = '0;
      CounterOverflow_i = 1'b0;
    end
    if (CounterClear_o && CounterEnable_o) overlap_cnt++;
    if (Valid_o && !prev_valid) valid_cnt++;
    if (CounterEnable_o) begin
      gate_run++;
    end else if (prev_en) begin
      last_gate = gate_run;
      gate_run  = 0;
      if (resp_q.size() > 0) begin
        r                 = resp_q.pop_front();
        CounterValue_i    = r.value;
        CounterOverflow_i = r.ovf;
      end
    end
    prev_en    = CounterEnable_o;
    prev_valid = Valid_o;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a DUT output to be high at a falling edge.
  // sel: 0 = CounterClear_o, 1 = Valid_o, 2 = CounterEnable_o.
  task automatic wait_for(input int sel, input int max_cyc, input string tag);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < max_cyc && !hit; n++) begin
      @(negedge Clock);
      case (sel)
        0:       hit = CounterClear_o;
        1:       hit = Valid_o;
        default: hit = CounterEnable_o;
      endcase
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int k_cyc;
  int c0;
  int v0;
  int stable_err;

  initial begin
    Reset    = 1'b1;
    Enable_i = 1'b0;
    Ready_i  = 1'b0;
    repeat (3) @(negedge Clock);

    // Reset state
    check("rst_valid",     {31'd0, Valid_o},         32'd0);
    check("rst_busy",      {31'd0, Busy_o},          32'd0);
    check("rst_clear",     {31'd0, CounterClear_o},  32'd0);
    check("rst_gate",      {31'd0, CounterEnable_o}, 32'd0);
    check("rst_result",    Result_o,                 32'd0);
    check("rst_overrange", {31'd0, Overrange_o},     32'd0);
    check("rst_range",     {30'd0, Range_o},         32'd0);

    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("idle_busy",  {31'd0, Busy_o},         32'd0);
    check("idle_clear", {31'd0, CounterClear_o}, 32'd0);

    // Basic: count 120 on the 1 s gate
    resp_q.push_back('{value: 8'd120, ovf: 1'b0});
    Enable_i = 1'b1;
    Ready_i  = 1'b1;
    @(negedge Clock);                       // edge k sampled Enable_i
    k_cyc = cyc;
    check("basic_clear",      {31'd0, CounterClear_o},  32'd1);
    check("basic_clear_gate", {31'd0, CounterEnable_o}, 32'd0);
    check("basic_busy",       {31'd0, Busy_o},          32'd1);
    @(negedge Clock);
    check("basic_clear_1cyc", {31'd0, CounterClear_o},  32'd0);
    check("basic_gate_on",    {31'd0, CounterEnable_o}, 32'd1);
    wait_for(1, 1100, "basic_valid_seen");
    // Valid_o in cycle k+3+G+SETTLE: G+SETTLE+2 edges after edge k
    check("basic_latency",   32'(cyc - k_cyc), 32'(CLOCK_HZ + SETTLE_CYCLES + 2));
    check("basic_gate_len",  32'(last_gate),   32'd1000);
    check("basic_result",    Result_o,         32'd120);
    check("basic_range",     {30'd0, Range_o}, 32'd0);
    check("basic_overrange", {31'd0, Overrange_o}, 32'd0);
    Enable_i = 1'b0;                        // handshake at next edge -> IDLE
    @(negedge Clock);
    check("basic_valid_drop", {31'd0, Valid_o}, 32'd0);
    check("basic_idle",       {31'd0, Busy_o},  32'd0);

    // Autorange: overflow at 1 s, count 40 at 100 ms, then back to 1 s
    repeat (2) @(negedge Clock);
    resp_q.push_back('{value: 8'd0,   ovf: 1'b1});
    resp_q.push_back('{value: 8'd40,  ovf: 1'b0});
    resp_q.push_back('{value: 8'd100, ovf: 1'b0});
    c0 = clear_cnt;
    v0 = valid_cnt;
    Enable_i = 1'b1;
    wait_for(1, 2000, "auto_valid_seen");
    check("auto_clears",   32'(clear_cnt - c0), 32'd2);
    check("auto_gate_len", 32'(last_gate),      32'd100);
    check("auto_result",   Result_o,            32'd400);
    check("auto_range",    {30'd0, Range_o},    32'd1);
    @(negedge Clock);                       // handshake with Enable_i=1
    check("auto_one_valid",  32'(valid_cnt - v0), 32'd1);
    check("auto_valid_drop", {31'd0, Valid_o},    32'd0);
    check("auto_reclear",    {31'd0, CounterClear_o}, 32'd1);
    Enable_i = 1'b0;                        // still publishes, then IDLE
    wait_for(1, 1100, "auto2_valid_seen");
    check("auto2_gate_len", 32'(last_gate),   32'd1000);
    check("auto2_result",   Result_o,         32'd100);
    check("auto2_range",    {30'd0, Range_o}, 32'd0);
    @(negedge Clock);
    check("auto2_idle", {31'd0, Busy_o}, 32'd0);

    // Overrange at every gate, published under backpressure
    repeat (2) @(negedge Clock);
    repeat (3) resp_q.push_back('{value: 8'd255, ovf: 1'b1});
    c0 = clear_cnt;
    v0 = valid_cnt;
    Ready_i  = 1'b0;
    Enable_i = 1'b1;
    wait_for(1, 1300, "over_valid_seen");
    check("over_clears",    32'(clear_cnt - c0), 32'd3);
    check("over_gate_len",  32'(last_gate),      32'd10);
    check("over_result",    Result_o,            32'hFFFF_FFFF);
    check("over_flag",      {31'd0, Overrange_o}, 32'd1);
    check("over_range",     {30'd0, Range_o},     32'd2);
    stable_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Valid_o !== 1'b1 || Result_o !== 32'hFFFF_FFFF || Overrange_o !== 1'b1 ||
          Range_o !== 2'd2 || CounterClear_o !== 1'b0)
        stable_err++;
    end
    check("bp_stable",     32'(stable_err),      32'd0);
    check("bp_one_valid",  32'(valid_cnt - v0),  32'd1);
    Ready_i = 1'b1;
    @(negedge Clock);
    check("bp_valid_drop", {31'd0, Valid_o},        32'd0);
    check("bp_clear",      {31'd0, CounterClear_o}, 32'd1);

    // Reset in the middle of the (10-cycle, range 2) gate
    resp_q.push_back('{value: 8'd0,  ovf: 1'b0});  // consumed by the aborted gate
    resp_q.push_back('{value: 8'd60, ovf: 1'b0});
    @(negedge Clock);
    @(negedge Clock);
    check("rg_in_gate", {31'd0, CounterEnable_o}, 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("rg_gate_off", {31'd0, CounterEnable_o}, 32'd0);
    check("rg_busy",     {31'd0, Busy_o},          32'd0);
    check("rg_valid",    {31'd0, Valid_o},         32'd0);
    check("rg_range",    {30'd0, Range_o},         32'd0);
    check("rg_result",   Result_o,                 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rg_restart_clear", {31'd0, CounterClear_o}, 32'd1);

    // Enable_i dropped mid-gate: full 1 s gate, publish, then IDLE
    repeat (10) @(negedge Clock);
    check("drop_in_gate", {31'd0, CounterEnable_o}, 32'd1);
    Enable_i = 1'b0;
    c0 = clear_cnt;
    wait_for(1, 1100, "drop_valid_seen");
    check("drop_gate_len", 32'(last_gate),   32'd1000);
    check("drop_result",   Result_o,         32'd60);
    check("drop_range",    {30'd0, Range_o}, 32'd0);
    repeat (30) @(negedge Clock);
    check("drop_idle",     {31'd0, Busy_o},     32'd0);
    check("drop_no_clear", 32'(clear_cnt - c0), 32'd0);

    check("no_clear_gate_overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
